// File: rtl/snes_pad_scanner.sv
// snes_pad_scanner: polls two daisy-clocked SNES pads and publishes both
// 16-bit button words atomically at the end of each scan frame.
module snes_pad_scanner #(
  parameter int unsigned CLOCK_FREQ_HZ = 18181818,
  parameter int unsigned POLL_HZ       = 60
) (
  input  logic        phi,
  input  logic        reset,
  output logic        snes_latch,
  output logic        snes_clock,
  input  logic        snes1_data,
  input  logic        snes2_data,
  output logic [15:0] joy1_data,
  output logic [15:0] joy2_data,
  output logic        frame_done,
  output logic        busy
);

  // Rounded division so both 18.18 MHz (109) and 1 MHz (6) land on the
  // intended 6 us half-bit tick.
  localparam int unsigned TICK_DIV = (CLOCK_FREQ_HZ + 83333) / 166667;
  localparam int unsigned POLL_DIV = CLOCK_FREQ_HZ / POLL_HZ;
  localparam int unsigned TW       = $clog2(TICK_DIV + 1);
  localparam int unsigned PW       = $clog2(POLL_DIV + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_CLK_LO = 3'd2;
  localparam logic [2:0] S_CLK_HI = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    bit_cnt;
  logic          latch_second;
  logic [15:0]   sh1, sh2;
  logic          s1_meta, s1_sync, s2_meta, s2_sync;
  logic          tick_end;

  assign tick_end = (tick_cnt == TICK_LAST);

  // Two-flop synchronisers for the asynchronous pad data lines.
  always_ff @(posedge phi) begin
    if (reset) begin
      s1_meta <= 1'b1;
      s1_sync <= 1'b1;
      s2_meta <= 1'b1;
      s2_sync <= 1'b1;
    end else begin
      s1_meta <= snes1_data;
      s1_sync <= s1_meta;
      s2_meta <= snes2_data;
      s2_sync <= s2_meta;
    end
  end

  // Free-running frame-rate divider.
  always_ff @(posedge phi) begin
    if (reset)                  poll_cnt <= '0;
    else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
    else                        poll_cnt <= poll_cnt + 1'b1;
  end

  // Scan state machine; pin outputs are registered alongside the state
  // transition so each pin changes in the first cycle of its new state.
  always_ff @(posedge phi) begin
    if (reset) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      latch_second <= 1'b0;
      sh1          <= '1;
      sh2          <= '1;
      joy1_data    <= '1;
      joy2_data    <= '1;
      snes_latch   <= 1'b0;
      snes_clock   <= 1'b1;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (poll_cnt == '0) begin
            state        <= S_LATCH;
            bit_cnt      <= '0;
            latch_second <= 1'b0;
            snes_latch   <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_LATCH: begin
          if (tick_end) begin
            tick_cnt <= '0;
            if (latch_second) begin
              state      <= S_CLK_LO;
              snes_latch <= 1'b0;
              snes_clock <= 1'b0;
            end else begin
              latch_second <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (tick_end) begin
            tick_cnt     <= '0;
            sh1[bit_cnt] <= s1_sync;
            sh2[bit_cnt] <= s2_sync;
            state        <= S_CLK_HI;
            snes_clock   <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (tick_end) begin
            tick_cnt <= '0;
            if (bit_cnt == 4'd15) begin
              // Publish in the DONE cycle itself: words, pulse and busy
              // all change together on entry.
              state      <= S_DONE;
              joy1_data  <= sh1;
              joy2_data  <= sh2;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              state      <= S_CLK_LO;
              snes_clock <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DONE: begin
          tick_cnt <= '0;
          state    <= S_IDLE;
        end
        default: begin
          tick_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
